// File: rtl/dmem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_pkg : shared states, store-size and load-type codes              |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_BYTE = 2'b01;
  localparam logic [1:0] BE_HALF = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder_if : request/response handshake bundle                 |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  byte_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, byte_en, funct3, addr, wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, byte_en, funct3, addr, wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_ram : single-port synchronous 32-bit RAM, 1-cycle registered read|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [31:0]       wdata_i,
  output logic      [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder : load/store responder with sub-word read-modify-write |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input wire logic        clk,
  input wire logic        reset,
  dmem_responder_if.slave bus
);

  state_t                state_q;
  logic [ADDR_W+1:0]     addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic [1:0]            be_q;
  logic [2:0]            f3_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  function automatic logic is_error(input logic we, input logic [1:0] be,
                                    input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (we) begin
      case (be)
        BE_NONE: e = 1'b1;
        BE_HALF: e = a[0];
        BE_WORD: e = (a != 2'b00);
        default: e = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: e = 1'b0;
        F3_LH, F3_LHU: e = a[0];
        F3_LW:         e = (a != 2'b00);
        default:       e = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Little-endian lane insert into the word read back from RAM.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] be, input logic [1:0] a);
    logic [31:0] m;
    m = word;
    case (be)
      BE_BYTE: m[{a, 3'b000} +: 8]     = wd[7:0];
      BE_HALF: m[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LW:   r = word;
      F3_LBU:  r = {24'h0, b};
      F3_LHU:  r = {16'h0, h};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Reset gates the write so an aborted sub-word store never lands.
  assign ram_we    = !reset && ((state_q == S_DATA && we_q) || state_q == S_WRITE);
  assign ram_wdata = (state_q == S_WRITE) ? wdata_q
                                          : merge_lanes(ram_rdata, wdata_q, be_q, addr_q[1:0]);

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      be_q        <= BE_NONE;
      f3_q        <= F3_LB;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.addr[ADDR_W+1:0];
            wdata_q     <= bus.wdata;
            we_q        <= bus.req_we;
            be_q        <= bus.byte_en;
            f3_q        <= bus.funct3;
            req_ready_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            if (is_error(bus.req_we, bus.byte_en, bus.funct3, bus.addr[1:0])) begin
              state_q <= S_ERR;
            end else if (bus.req_we && bus.byte_en == BE_WORD) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: state_q <= S_DATA;
        S_DATA: begin
          rsp_rdata_q <= we_q ? 32'h0 : extend_load(ram_rdata, f3_q, addr_q[1:0]);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_ERR: begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= 32'h0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dmem_responder : directed table, corner sequences, random vs model |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t tbl [16];
  logic [7:0] mm [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] be, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.byte_en   = be;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = c;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
    if (lat > 0) @(posedge clk);
  endtask

  // Byte-array reference: classify, then read or write the addressed bytes.
  task automatic model(input logic we, input logic [1:0] be, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    int i, nb;
    logic [31:0] v;
    i  = int'(a[9:0]);
    er = 1'b0;
    if (we) begin
      if (be == 0) er = 1'b1;
      else if (be == 2) er = (i % 2) != 0;
      else if (be == 3) er = (i % 4) != 0;
    end else begin
      if (f3 == 0 || f3 == 4) er = 1'b0;
      else if (f3 == 1 || f3 == 5) er = (i % 2) != 0;
      else if (f3 == 2) er = (i % 4) != 0;
      else er = 1'b1;
    end
    rd = 32'h0;
    if (er) begin
      lat = 2;
    end else if (we) begin
      nb = (be == 1) ? 1 : (be == 2) ? 2 : 4;
      for (int k = 0; k < nb; k++) mm[i + k] = wd[8*k +: 8];
      lat = (be == 3) ? 2 : 3;
    end else begin
      nb = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
      v  = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(mm[i + k]) << (8 * k));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
      rd  = v;
      lat = 3;
    end
  endtask

  initial begin
    logic [31:0] rd, erd, a, wd;
    logic        er, eer, we;
    logic [1:0]  be;
    logic [2:0]  f3;
    int          lat, elat, n;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.byte_en   = 2'b00;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;

    tbl[0]  = '{1'b1, 2'b11, 3'b000, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, "SW 10"};
    tbl[1]  = '{1'b0, 2'b00, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, "LW 10 a"};
    tbl[2]  = '{1'b1, 2'b01, 3'b000, 32'h11,  32'h00000080, 32'h0,        1'b0, 3, "SB 11"};
    tbl[3]  = '{1'b0, 2'b00, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 3, "LW 10 b"};
    tbl[4]  = '{1'b0, 2'b00, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, 3, "LB 11"};
    tbl[5]  = '{1'b0, 2'b00, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0, 3, "LBU 11"};
    tbl[6]  = '{1'b1, 2'b10, 3'b000, 32'h12,  32'h00001234, 32'h0,        1'b0, 3, "SH 12"};
    tbl[7]  = '{1'b0, 2'b00, 3'b010, 32'h10,  32'h0,        32'h123480EF, 1'b0, 3, "LW 10 c"};
    tbl[8]  = '{1'b0, 2'b00, 3'b001, 32'h12,  32'h0,        32'h00001234, 1'b0, 3, "LH 12"};
    tbl[9]  = '{1'b0, 2'b00, 3'b101, 32'h10,  32'h0,        32'h000080EF, 1'b0, 3, "LHU 10"};
    tbl[10] = '{1'b0, 2'b00, 3'b010, 32'h13,  32'h0,        32'h0,        1'b1, 2, "LW 13 err"};
    tbl[11] = '{1'b0, 2'b00, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1, 2, "LH 11 err"};
    tbl[12] = '{1'b0, 2'b00, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 2, "F3 011 err"};
    tbl[13] = '{1'b1, 2'b00, 3'b000, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1, 2, "BE 00 err"};
    tbl[14] = '{1'b0, 2'b00, 3'b010, 32'h10,  32'h0,        32'h123480EF, 1'b0, 3, "LW 10 d"};
    tbl[15] = '{1'b0, 2'b00, 3'b010, 32'h410, 32'h0,        32'h123480EF, 1'b0, 3, "LW alias"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst rsp_err",   {31'h0, bus.rsp_err},   32'h0);
    chk("rst rsp_rdata", bus.rsp_rdata,          32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", {31'h0, bus.req_ready}, 32'h1);

    for (int t = 0; t < 16; t++) begin
      xact(tbl[t].we, tbl[t].be, tbl[t].f3, tbl[t].a, tbl[t].wd, rd, er, lat);
      chk({tbl[t].nm, " rdata"}, rd, tbl[t].exp_rd);
      chk({tbl[t].nm, " err"},   {31'h0, er}, {31'h0, tbl[t].exp_err});
      chk({tbl[t].nm, " lat"},   32'(lat), 32'(tbl[t].exp_lat));
    end

    // Stall the response; a competing request during RESP must be dropped.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold reached", {31'h0, bus.rsp_valid}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.byte_en   = 2'b11;
    bus.wdata     = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("hold rsp_rdata", bus.rsp_rdata,          32'h123480EF);
      chk("hold req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);

    // Abort a sub-word store by resetting during its merge cycle.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.byte_en   = 2'b01;
    bus.addr      = 32'h10;
    bus.wdata     = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort req_ready", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("abort idle",      {31'h0, bus.req_ready}, 32'h1);
    xact(1'b0, 2'b00, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("abort LW rdata", rd, 32'h123480EF);
    chk("abort LW lat",   32'(lat), 32'd3);

    for (int w = 0; w < 8; w++) begin
      a  = 32'h80 + 32'(4 * w);
      wd = $urandom;
      model(1'b1, 2'b11, 3'b000, a, wd, erd, eer, elat);
      xact(1'b1, 2'b11, 3'b000, a, wd, rd, er, lat);
      chk("init lat", 32'(lat), 32'(elat));
    end
    for (int r = 0; r < 80; r++) begin
      we = 1'($urandom % 2);
      be = 2'($urandom % 4);
      f3 = 3'($urandom % 8);
      a  = (32'h80 + ($urandom % 32)) | ($urandom << 10);
      wd = $urandom;
      model(we, be, f3, a, wd, erd, eer, elat);
      xact(we, be, f3, a, wd, rd, er, lat);
      chk("rand rdata", rd, erd);
      chk("rand err",   {31'h0, er}, {31'h0, eer});
      chk("rand lat",   32'(lat), 32'(elat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
